hilo_divider: RTL

//  Multi-cycle iterative 32-bit divider; owns the HI/LO register pair read by mfhi/mflo.

---
 rtl/hilo_divider.sv | 117 +++++++++++
 1 files changed

// File: rtl/hilo_divider.sv
// Iterative restoring divider that owns the HI/LO pair: Lo = quotient, Hi = remainder.
// One quotient bit per clock, followed by a single sign fix-up cycle.
module hilo_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] a_raw;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;
  logic             b_zero;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_sub;
  logic             take;

  always_comb begin
    a_neg     = signed_div & a[WIDTH-1];
    b_neg     = signed_div & b[WIDTH-1];
    a_abs     = a_neg ? -a : a;
    b_abs     = b_neg ? -b : b;
    rem_shift = {rem, dvd[WIDTH-1]};
    take      = rem_shift >= {1'b0, dvs};
    // The difference always fits in WIDTH bits because it is smaller than the divisor.
    rem_sub   = rem_shift[WIDTH-1:0] - dvs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      quo      <= '0;
      a_raw    <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      b_zero   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd      <= a_abs;
            dvs      <= b_abs;
            a_raw    <= a;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            b_zero   <= (b == '0);
            busy     <= 1'b1;
            div_zero <= 1'b0;
            state    <= DIV;
          end
        end
        DIV: begin
          rem <= take ? rem_sub : rem_shift[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], take};
          dvd <= {dvd[WIDTH-2:0], 1'b0};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          // A zero divisor bypasses sign handling and reports the raw dividend.
          if (b_zero) begin
            lo <= '1;
            hi <= a_raw;
          end else begin
            lo <= neg_q ? -quo : quo;
            hi <= neg_r ? -rem : rem;
          end
          div_zero <= b_zero;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
